spi_msg_seq: RTL

SPI_MSG_SEQ -- requirements
Module: spi_msg_seq

---
 rtl/spi_msg_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/spi_msg_seq.sv
// SPI slave message sequencer: decodes command bytes from the host and turns
// them into status replies, 32-bit register reads and 32-bit register writes.
module spi_msg_seq #(
  parameter logic [7:0]  STATUS_BYTE = 8'h5A,
  parameter int unsigned NREG_BITS   = 4
) (
  input  logic                 sysClk,
  input  logic                 usrReset,
  input  logic                 ssActive,
  input  logic                 rxValid,
  input  logic [7:0]           rxData,
  output logic                 txLoad,
  output logic [7:0]           txData,
  output logic [NREG_BITS-1:0] regAddr,
  output logic                 regRd,
  input  logic [31:0]          regRdData,
  output logic                 regWr,
  output logic [31:0]          regWrData,
  output logic                 busy,
  output logic                 cmdErr
);

  typedef enum logic [2:0] {S_CMD, S_STAT, S_RD, S_WR, S_ERR} state_e;
  typedef enum logic [1:0] {K_ZERO, K_STAT, K_RDFIRST, K_RDBYTE} kind_e;

  state_e               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 p1_vld_q, p1_vld_d;
  kind_e                kind_q, kind_d;
  logic [1:0]           idx_q, idx_d;
  logic                 txload_q, txload_d;
  logic [7:0]           tx_q, tx_d;
  logic                 rdsel_q, rdsel_d;
  logic [31:0]          rdword_q, rdword_d;
  logic                 regrd_q, regrd_d;
  logic                 regwr_q, regwr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [NREG_BITS-1:0] addr_q, addr_d;
  logic                 busy_q, busy_d;
  logic                 cmderr_q, cmderr_d;
  logic                 rx_go;

  assign rx_go = rxValid && ssActive;

  // State register
  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      state_q <= S_CMD;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ssActive) begin
      state_d = S_CMD;
      cnt_d   = 2'd0;
    end else if (rxValid) begin
      case (state_q)
        S_CMD: begin
          cnt_d = 2'd0;
          case (rxData[7:6])
            2'b00:   state_d = S_STAT;
            2'b10:   state_d = S_RD;
            2'b11:   state_d = S_WR;
            default: state_d = S_ERR;
          endcase
        end
        S_STAT: state_d = S_CMD;
        S_RD, S_WR: begin
          if (cnt_q == 2'd3) begin
            state_d = S_CMD;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        S_ERR:   state_d = S_ERR;
        default: state_d = S_CMD;
      endcase
    end
  end

  // Output / datapath logic: byte stage (c+1) then tx stage (c+2)
  always_comb begin
    p1_vld_d = 1'b0;
    kind_d   = K_ZERO;
    idx_d    = cnt_q;
    regrd_d  = 1'b0;
    regwr_d  = 1'b0;
    cmderr_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (rx_go) begin
      p1_vld_d = 1'b1;
      case (state_q)
        S_CMD: begin
          case (rxData[7:6])
            2'b00: kind_d = K_STAT;
            2'b10: begin
              kind_d  = K_RDFIRST;
              regrd_d = 1'b1;
              addr_d  = rxData[NREG_BITS-1:0];
            end
            2'b11:   addr_d = rxData[NREG_BITS-1:0];
            default: cmderr_d = 1'b1;
          endcase
        end
        S_RD: if (cnt_q != 2'd3) kind_d = K_RDBYTE;
        S_WR: begin
          wdata_d = {wdata_q[23:0], rxData};
          regwr_d = (cnt_q == 2'd3);
        end
        default: kind_d = K_ZERO;
      endcase
    end

    txload_d = p1_vld_q && ssActive;
    case (kind_q)
      K_STAT:  tx_d = STATUS_BYTE;
      K_RDBYTE: begin
        case (idx_q)
          2'd0:    tx_d = rdword_q[23:16];
          2'd1:    tx_d = rdword_q[15:8];
          default: tx_d = rdword_q[7:0];
        endcase
      end
      default: tx_d = 8'h00;
    endcase
    rdsel_d  = txload_d && (kind_q == K_RDFIRST);
    rdword_d = rdsel_q ? regRdData : rdword_q;
    busy_d   = (state_d != S_CMD);
  end

  always_ff @(posedge sysClk or posedge usrReset) begin
    if (usrReset) begin
      p1_vld_q <= 1'b0;
      kind_q   <= K_ZERO;
      idx_q    <= 2'd0;
      txload_q <= 1'b0;
      tx_q     <= 8'h00;
      rdsel_q  <= 1'b0;
      rdword_q <= 32'd0;
      regrd_q  <= 1'b0;
      regwr_q  <= 1'b0;
      wdata_q  <= 32'd0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      cmderr_q <= 1'b0;
    end else begin
      p1_vld_q <= p1_vld_d;
      kind_q   <= kind_d;
      idx_q    <= idx_d;
      txload_q <= txload_d;
      tx_q     <= tx_d;
      rdsel_q  <= rdsel_d;
      rdword_q <= rdword_d;
      regrd_q  <= regrd_d;
      regwr_q  <= regwr_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      cmderr_q <= cmderr_d;
    end
  end

  // Read data only arrives in the first reply slot, so that slot bypasses tx_q
  assign txData    = rdsel_q ? regRdData[31:24] : tx_q;
  assign txLoad    = txload_q;
  assign regAddr   = addr_q;
  assign regRd     = regrd_q;
  assign regWr     = regwr_q;
  assign regWrData = wdata_q;
  assign busy      = busy_q;
  assign cmdErr    = cmderr_q;

endmodule
